// File: rtl/store_pkg.sv
// Shared types, catalogue codes and helpers for the checkout front end.
package store_pkg;

    typedef logic [2:0] upc_t;

    // The six items the store stocks; 3'b010 and 3'b111 are not in the catalogue.
    localparam upc_t UPC_ITEM_0 = 3'b000;
    localparam upc_t UPC_ITEM_1 = 3'b001;
    localparam upc_t UPC_ITEM_2 = 3'b011;
    localparam upc_t UPC_ITEM_3 = 3'b100;
    localparam upc_t UPC_ITEM_4 = 3'b101;
    localparam upc_t UPC_ITEM_5 = 3'b110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHOW    = 2'd2,
        ERR     = 2'd3
    } scan_state_t;

    // True when the code names a catalogue item.
    function automatic logic upc_is_valid(input upc_t code);
        logic ok;
        case (code)
            UPC_ITEM_0, UPC_ITEM_1, UPC_ITEM_2,
            UPC_ITEM_3, UPC_ITEM_4, UPC_ITEM_5: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizes an active-low push key, debounces it and flags clean presses.
// level is 1 while the debounced key is pressed; rise_evt pulses for one
// cycle when the debounced level goes from released to pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic rise_evt
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1: the next differing cycle flips.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_r;
    logic             sync_r;
    logic             key_s;
    logic             level_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;

    // Two-flop synchronizer kept in raw polarity so reset means released.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= raw_n;
            sync_r <= meta_r;
        end
    end

    assign key_s = ~sync_r;

    // Debounce counter, debounced level and registered press pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
        end else if (key_s != level_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                level_r <= key_s;
                rise_r  <= key_s;
            end else begin
                cnt_r   <= cnt_r + CNT_W'(1);
                level_r <= level_r;
                rise_r  <= 1'b0;
            end
        end else begin
            cnt_r   <= '0;
            level_r <= level_r;
            rise_r  <= 1'b0;
        end
    end

    assign level    = level_r;
    assign rise_evt = rise_r;

endmodule

// File: rtl/upc_scan_latch.sv
// Checkout front end: synchronizes the UPC switches, debounces the scan key,
// latches the UPC on each clean press and validates it against the catalogue.
// Optional feature macro: UPC_SCAN_COUNT_EN enables the saturating count of
// successful scans; without it scan_count is tied to zero.
module upc_scan_latch
    import store_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] upc_in,
    input  logic       scan_n,
    input  logic       clear,
    output logic [2:0] upc_out,
    output logic       upc_valid,
    output logic       scan_error,
    output logic [3:0] scan_count
);

    upc_t        upc_meta_r;
    upc_t        upc_sync_r;
    logic        key_level_s;
    logic        rise_s;
    logic        press_s;
    logic        capture_ok_s;
    scan_state_t state_r;
    scan_state_t state_nxt_s;
    upc_t        upc_r;
    logic        valid_r;
    logic        err_r;
    upc_t        upc_nxt_s;
    logic        valid_nxt_s;
    logic        err_nxt_s;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk     (clk),
        .reset   (reset),
        .raw_n   (scan_n),
        .level   (key_level_s),
        .rise_evt(rise_s)
    );

    // A press is honoured only while the debounced key reads pressed.
    assign press_s      = rise_s & key_level_s;
    assign capture_ok_s = upc_is_valid(upc_sync_r);

    // Two-flop synchronizer for the UPC switches.
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_meta_r <= 3'b000;
            upc_sync_r <= 3'b000;
        end else begin
            upc_meta_r <= upc_in;
            upc_sync_r <= upc_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; clear overrides any pending press.
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE, SHOW, ERR: begin
                    if (press_s) begin
                        state_nxt_s = CAPTURE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                CAPTURE: begin
                    if (capture_ok_s) begin
                        state_nxt_s = SHOW;
                    end else begin
                        state_nxt_s = ERR;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // FSM output logic: next values for the latched UPC and status flags.
    always_comb begin
        upc_nxt_s   = upc_r;
        valid_nxt_s = valid_r;
        err_nxt_s   = err_r;
        if (clear) begin
            upc_nxt_s   = 3'b000;
            valid_nxt_s = 1'b0;
            err_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                CAPTURE: begin
                    if (capture_ok_s) begin
                        upc_nxt_s   = upc_sync_r;
                        valid_nxt_s = 1'b1;
                        err_nxt_s   = 1'b0;
                    end else begin
                        upc_nxt_s   = upc_r;
                        valid_nxt_s = 1'b0;
                        err_nxt_s   = 1'b1;
                    end
                end
                IDLE, SHOW, ERR: begin
                    upc_nxt_s   = upc_r;
                    valid_nxt_s = valid_r;
                    err_nxt_s   = err_r;
                end
                default: begin
                    upc_nxt_s   = 3'b000;
                    valid_nxt_s = 1'b0;
                    err_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // Output registers feeding storeDisplay.
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_r   <= 3'b000;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            upc_r   <= upc_nxt_s;
            valid_r <= valid_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign upc_out    = upc_r;
    assign upc_valid  = valid_r;
    assign scan_error = err_r;

`ifdef UPC_SCAN_COUNT_EN
    logic [3:0] count_r;

    // Saturating count of valid captures; clear leaves it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if ((state_r == CAPTURE) && capture_ok_s && !clear && (count_r != 4'd15)) begin
            count_r <= count_r + 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign scan_count = count_r;
`else
    assign scan_count = 4'd0;
`endif

endmodule

// File: tb/tb_upc_scan_latch.sv
// Self-checking bench for upc_scan_latch (DEBOUNCE_CYCLES = 4).
// Expected output states are pushed to a scoreboard queue when a press is
// driven and popped when the DUT is due to show them (8th edge).
module tb_upc_scan_latch;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] upc_in;
    logic       scan_n;
    logic       clear;
    logic [2:0] upc_out;
    logic       upc_valid;
    logic       scan_error;
    logic [3:0] scan_count;

    typedef struct packed {
        logic [2:0] upc;
        logic       valid;
        logic       err;
        logic [3:0] cnt;
    } obs_t;

    obs_t obs;
    obs_t cur;
    obs_t e;
    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    upc_scan_latch #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .upc_in    (upc_in),
        .scan_n    (scan_n),
        .clear     (clear),
        .upc_out   (upc_out),
        .upc_valid (upc_valid),
        .scan_error(scan_error),
        .scan_count(scan_count)
    );

    always #5 clk = ~clk;

    assign obs = {upc_out, upc_valid, scan_error, scan_count};

    // Reference behaviour of one capture of code from state s.
    function automatic obs_t model_capture(input obs_t s, input logic [2:0] code);
        obs_t r;
        r = s;
        if (code != 3'b010 && code != 3'b111) begin
            r.upc   = code;
            r.valid = 1'b1;
            r.err   = 1'b0;
`ifdef UPC_SCAN_COUNT_EN
            if (r.cnt != 4'd15) r.cnt = r.cnt + 4'd1;
`endif
        end else begin
            r.valid = 1'b0;
            r.err   = 1'b1;
        end
        return r;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_key();
        scan_n = 1'b1;
        cycles(12);
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; scan_n = 1'b0; upc_in = 3'b001;
        cycles(2);
        n_cmp++;
        if (obs !== 9'b0) $display("FAIL reset_state: got %b want %b", obs, 9'b0);
        cur = '0;
        reset = 1'b0;
        exp_q.push_back(model_capture(cur, 3'b001));
        cycles(7);
        n_cmp++;
        if (obs !== cur) begin n_bad++; $display("FAIL reset_held_early: got %b want %b", obs, cur); end
        cycles(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_held_capture: got %b want %b", obs, e); end
        cur = e;
        release_key();
    endtask

    task automatic test_valid_scan();
        upc_in = 3'b101; scan_n = 1'b0;
        exp_q.push_back(model_capture(cur, 3'b101));
        cycles(7);
        n_cmp++;
        if (obs !== cur) begin n_bad++; $display("FAIL valid_edge7: got %b want %b", obs, cur); end
        cycles(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL valid_edge8: got %b want %b", obs, e); end
        cur = e;
        cycles(2);
        release_key();
    endtask

    task automatic test_bounce();
        upc_in = 3'b110;
        for (int i = 0; i < 4; i++) begin
            scan_n = 1'b0; cycles(3);
            scan_n = 1'b1; cycles(1);
        end
        cycles(10);
        n_cmp++;
        if (obs !== cur) begin n_bad++; $display("FAIL bounce_no_capture: got %b want %b", obs, cur); end
        upc_in = 3'b101; scan_n = 1'b0;
        exp_q.push_back(model_capture(cur, 3'b101));
        cycles(6);
        scan_n = 1'b1;
        cycles(4);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL bounce_hold_capture: got %b want %b", obs, e); end
        cur = e;
        cycles(12);
        n_cmp++;
        if (obs !== cur) begin n_bad++; $display("FAIL bounce_release_quiet: got %b want %b", obs, cur); end
    endtask

    task automatic test_invalid_then_valid();
        upc_in = 3'b111; scan_n = 1'b0;
        exp_q.push_back(model_capture(cur, 3'b111));
        cycles(8);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL invalid_code: got %b want %b", obs, e); end
        cur = e;
        release_key();
        upc_in = 3'b011; scan_n = 1'b0;
        exp_q.push_back(model_capture(cur, 3'b011));
        cycles(8);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL valid_after_invalid: got %b want %b", obs, e); end
        cur = e;
        upc_in = 3'b110;
        cycles(20);
        n_cmp++;
        if (obs !== cur) begin n_bad++; $display("FAIL held_single_capture: got %b want %b", obs, cur); end
        release_key();
    endtask

    task automatic test_clear_collision();
        obs_t c;
        upc_in = 3'b100; scan_n = 1'b0;
        c = cur; c.upc = 3'b000; c.valid = 1'b0; c.err = 1'b0;
        exp_q.push_back(c);
        cycles(6);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL clear_collision: got %b want %b", obs, e); end
        cur = e;
        cycles(12);
        n_cmp++;
        if (obs !== cur) begin n_bad++; $display("FAIL clear_no_retrigger: got %b want %b", obs, cur); end
        release_key();
    endtask

    task automatic test_reset_mid_debounce();
        upc_in = 3'b100; scan_n = 1'b0;
        cycles(4);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cur = '0;
        n_cmp++;
        if (obs !== cur) begin n_bad++; $display("FAIL reset_mid_state: got %b want %b", obs, cur); end
        exp_q.push_back(model_capture(cur, 3'b100));
        cycles(7);
        n_cmp++;
        if (obs !== cur) begin n_bad++; $display("FAIL reset_mid_redebounce: got %b want %b", obs, cur); end
        cycles(1);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_mid_capture: got %b want %b", obs, e); end
        cur = e;
        release_key();
    endtask

    task automatic test_saturation();
        logic [2:0] codes [6];
        logic [3:0] want_cnt;
        codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b011;
        codes[3] = 3'b100; codes[4] = 3'b101; codes[5] = 3'b110;
        for (int i = 0; i < 17; i++) begin
            upc_in = codes[i % 6]; scan_n = 1'b0;
            exp_q.push_back(model_capture(cur, codes[i % 6]));
            cycles(8);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL saturation_press%0d: got %b want %b", i, obs, e); end
            cur = e;
            release_key();
        end
`ifdef UPC_SCAN_COUNT_EN
        want_cnt = 4'd15;
`else
        want_cnt = 4'd0;
`endif
        n_cmp++;
        if (scan_count !== want_cnt) begin n_bad++; $display("FAIL saturation_final: got %0d want %0d", scan_count, want_cnt); end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; scan_n = 1'b1; upc_in = 3'b000;
        cur = '0;
        test_reset();
        test_valid_scan();
        test_bounce();
        test_invalid_then_valid();
        test_clear_collision();
        test_reset_mid_debounce();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
